// File: rtl/spi_subunit_if.sv
// Pin and local-side signal bundle for the SPI responder.
// The master modport is the controller/local-logic side; the slave modport is the responder.
interface spi_subunit_if;
  logic       SPI_SCLK;
  logic       SPI_MOSI;
  logic       SPI_CS;
  logic       SPI_MISO;
  logic [7:0] send_data;
  logic [7:0] data_received;
  logic       received_valid;
  logic       busy;
  logic       abort;

  modport master (
    output SPI_SCLK, SPI_MOSI, SPI_CS, send_data,
    input  SPI_MISO, data_received, received_valid, busy, abort
  );

  modport slave (
    input  SPI_SCLK, SPI_MOSI, SPI_CS, send_data,
    output SPI_MISO, data_received, received_valid, busy, abort
  );
endinterface

// File: rtl/spi_subunit.sv
// SPI mode-0 responder: oversampled pins, MSB-first receive on SCLK rise,
// MISO advance on SCLK fall, multi-byte frames while CS stays low.
module spi_subunit #(
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  spi_subunit_if.slave bus
);

  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [DEPTH-1:0] sclk_sync;
  logic [DEPTH-1:0] mosi_sync;
  logic [DEPTH-1:0] cs_sync;
  logic [DEPTH:0]   fill;
  logic             sclk_s;
  logic             cs_s;

  logic sclk_p0;
  logic cs_p0;
  logic vld_p0;

  logic sclk_rise_p1;
  logic sclk_fall_p1;
  logic cs_rise_p1;
  logic cs_fall_p1;
  logic mosi_p1;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [6:0] tx_sh;
  logic       miso;
  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       busy_q;
  logic       abort_q;

  // Synchronizer chains; fill marks when the chain plus the edge copy hold real samples
  // so the reset value of CS cannot masquerade as a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[DEPTH-2:0], bus.SPI_SCLK};
      mosi_sync <= {mosi_sync[DEPTH-2:0], bus.SPI_MOSI};
      cs_sync   <= {cs_sync[DEPTH-2:0], bus.SPI_CS};
      fill      <= {fill[DEPTH-1:0], 1'b1};
    end
  end

  assign sclk_s = sclk_sync[DEPTH-1];
  assign cs_s   = cs_sync[DEPTH-1];
  assign vld_p0 = fill[DEPTH];

  // Stage p0: previous synchronized sample for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_p0 <= 1'b0;
      cs_p0   <= 1'b1;
    end else begin
      sclk_p0 <= sclk_s;
      cs_p0   <= cs_s;
    end
  end

  // Stage p1: registered edge strobes with MOSI aligned to the SCLK edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_rise_p1 <= 1'b0;
      sclk_fall_p1 <= 1'b0;
      cs_rise_p1   <= 1'b0;
      cs_fall_p1   <= 1'b0;
      mosi_p1      <= 1'b0;
    end else begin
      sclk_rise_p1 <= vld_p0 &  sclk_s & ~sclk_p0;
      sclk_fall_p1 <= vld_p0 & ~sclk_s &  sclk_p0;
      cs_rise_p1   <= vld_p0 &  cs_s   & ~cs_p0;
      cs_fall_p1   <= vld_p0 & ~cs_s   &  cs_p0;
      mosi_p1      <= mosi_sync[DEPTH-1];
    end
  end

  // Stage p2: frame FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
      tx_sh   <= 7'd0;
      miso    <= 1'b0;
      rx_byte <= 8'd0;
      rx_vld  <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      rx_vld  <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall_p1) begin
            state   <= ACTIVE;
            tx_sh   <= bus.send_data[6:0];
            miso    <= bus.send_data[7];
            bit_cnt <= 3'd0;
            busy_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          // CS release wins over any SCLK edge seen in the same cycle.
          if (cs_rise_p1) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            miso    <= 1'b0;
            abort_q <= (bit_cnt != 3'd0);
            bit_cnt <= 3'd0;
          end else if (sclk_rise_p1) begin
            rx_sh   <= {rx_sh[5:0], mosi_p1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_byte <= {rx_sh, mosi_p1};
              rx_vld  <= 1'b1;
            end
          end else if (sclk_fall_p1) begin
            if (bit_cnt != 3'd0) begin
              miso  <= tx_sh[6];
              tx_sh <= {tx_sh[5:0], 1'b0};
            end else begin
              tx_sh <= bus.send_data[6:0];
              miso  <= bus.send_data[7];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SPI_MISO       = miso;
  assign bus.data_received  = rx_byte;
  assign bus.received_valid = rx_vld;
  assign bus.busy           = busy_q;
  assign bus.abort          = abort_q;

endmodule

// File: tb/tb_spi_subunit.sv
// Bench for spi_subunit: acts as a mode-0 SPI controller, keeps a frame-level
// model (expected bytes, pending aborts, delayed CS activity) and checks every cycle.
module tb_spi_subunit;

  localparam int SS   = 2;
  localparam int HALF = 8;
  localparam int LAG  = SS + 1;

  logic clk;
  logic rst;
  spi_subunit_if bus();

  spi_subunit #(.SYNC_STAGES(SS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         abort_pending = 0;
  logic       bq[$];
  logic       seen_high = 1'b0;
  logic       busy_exp;
  logic [7:0] exp_byte;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model history: one entry per clock of "frame should be active", from CS pin samples.
  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      seen_high = 1'b0;
    end else begin
      bq.push_back(!bus.SPI_CS && seen_high);
      if (bus.SPI_CS) seen_high = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {bus.SPI_MISO, bus.data_received, bus.received_valid, bus.busy, bus.abort}, 32'd0);
    end else begin
      busy_exp = (bq.size() > LAG) ? bq[bq.size()-1-LAG] : 1'b0;
      chk("busy", bus.busy, busy_exp);
      if (!busy_exp) chk("miso_idle", bus.SPI_MISO, 1'b0);
      chk("rv_abort_exclusive", bus.received_valid & bus.abort, 1'b0);
      if (bus.received_valid) begin
        chk("rv_expected", rx_q.size() > 0, 1'b1);
        if (rx_q.size() > 0) begin
          exp_byte = rx_q.pop_front();
          chk("rx_byte", bus.data_received, exp_byte);
        end
      end
      if (bus.abort) begin
        chk("abort_expected", abort_pending > 0, 1'b1);
        if (abort_pending > 0) abort_pending--;
      end
    end
  end

  // Waits HALF clocks; reports the first clock at which MISO changed / received_valid was high.
  task automatic half(output int ml, output int rl);
    logic prev;
    prev = bus.SPI_MISO;
    ml = -1;
    rl = -1;
    for (int n = 1; n <= HALF; n++) begin
      @(posedge clk);
      #3;
      if (ml < 0 && bus.SPI_MISO !== prev) ml = n;
      if (rl < 0 && bus.received_valid) rl = n;
    end
  endtask

  task automatic frame_start();
    int a, b;
    bus.SPI_CS = 1'b0;
    half(a, b);
  endtask

  task automatic frame_end();
    int a, b;
    bus.SPI_CS = 1'b1;
    half(a, b);
    half(a, b);
  endtask

  task automatic xfer(input int nbits, input logic [7:0] mo, input logic [7:0] exp_mi,
                      input logic [7:0] next_send, input bit push, input string name,
                      output int fall_lat, output int rv_lat);
    logic [7:0] got;
    int ml, rl;
    got = 8'd0;
    fall_lat = -1;
    rv_lat = -1;
    if (push && nbits == 8) rx_q.push_back(mo);
    for (int i = 0; i < nbits; i++) begin
      bus.SPI_MOSI = mo[7-i];
      half(ml, rl);
      if (i == 1) fall_lat = ml;
      bus.SPI_SCLK = 1'b1;
      if (i == 7) bus.send_data = next_send;
      half(ml, rl);
      if (i == 7) rv_lat = rl;
      got = {got[6:0], bus.SPI_MISO};
      bus.SPI_SCLK = 1'b0;
    end
    half(ml, rl);
    bus.SPI_MOSI = 1'b0;
    if (nbits == 8) chk(name, got, exp_mi);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, rl;
    bus.SPI_SCLK  = 1'b0;
    bus.SPI_MOSI  = 1'b0;
    bus.SPI_CS    = 1'b1;
    bus.send_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_data", bus.data_received, 8'h00);
    chk("reset_miso", bus.SPI_MISO, 1'b0);
    rst = 1'b0;
    half(fl, rl);
    half(fl, rl);

    // Single byte
    bus.send_data = 8'h3C;
    frame_start();
    xfer(8, 8'hA5, 8'h3C, 8'h3C, 1'b1, "t1_ctrl_rx", fl, rl);
    frame_end();
    chk("t1_data_received", bus.data_received, 8'hA5);

    // Abort after three bits 1,0,1
    bus.send_data = 8'h11;
    frame_start();
    xfer(3, 8'hA0, 8'h00, 8'h11, 1'b0, "t3_partial", fl, rl);
    abort_pending++;
    frame_end();
    chk("t3_data_held", bus.data_received, 8'hA5);
    chk("t3_busy", bus.busy, 1'b0);
    chk("t3_miso", bus.SPI_MISO, 1'b0);

    // Two-byte frame with send_data reload between bytes
    bus.send_data = 8'h55;
    frame_start();
    xfer(8, 8'h81, 8'h55, 8'hAA, 1'b1, "t2_ctrl_rx0", fl, rl);
    chk("t2_data0", bus.data_received, 8'h81);
    xfer(8, 8'h7E, 8'hAA, 8'hAA, 1'b1, "t2_ctrl_rx1", fl, rl);
    frame_end();
    chk("t2_data1", bus.data_received, 8'h7E);

    // Reset in the middle of a frame, then CS still low at release
    bus.send_data = 8'h99;
    frame_start();
    xfer(4, 8'hF0, 8'h00, 8'h99, 1'b0, "t4_partial", fl, rl);
    rst = 1'b1;
    #1;
    chk("t4_rst_data", bus.data_received, 8'h00);
    chk("t4_rst_busy", bus.busy, 1'b0);
    chk("t4_rst_miso", bus.SPI_MISO, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    half(fl, rl);
    half(fl, rl);
    half(fl, rl);
    chk("t4_no_frame_busy", bus.busy, 1'b0);
    xfer(8, 8'h77, 8'h00, 8'h99, 1'b0, "t4_idle_miso", fl, rl);
    chk("t4_idle_data", bus.data_received, 8'h00);
    frame_end();
    bus.send_data = 8'h5A;
    frame_start();
    xfer(8, 8'h0F, 8'h5A, 8'h5A, 1'b1, "t4_ctrl_rx", fl, rl);
    frame_end();
    chk("t4_data_received", bus.data_received, 8'h0F);

    // Corner data, back-to-back frames
    bus.send_data = 8'hFF;
    frame_start();
    xfer(8, 8'h00, 8'hFF, 8'hFF, 1'b1, "t5_ctrl_rx_ff", fl, rl);
    frame_end();
    chk("t5_data_00", bus.data_received, 8'h00);
    bus.send_data = 8'h00;
    frame_start();
    xfer(8, 8'hFF, 8'h00, 8'h00, 1'b1, "t5_ctrl_rx_00", fl, rl);
    frame_end();
    chk("t5_data_ff", bus.data_received, 8'hFF);

    // Edge latency
    bus.send_data = 8'hAA;
    frame_start();
    xfer(8, 8'h3C, 8'hAA, 8'hAA, 1'b1, "t6_ctrl_rx", fl, rl);
    chk("t6_miso_latency", fl, SS + 2);
    chk("t6_rv_latency", rl, SS + 2);
    frame_end();
    chk("t6_data_received", bus.data_received, 8'h3C);

    half(fl, rl);
    chk("rx_queue_drained", rx_q.size(), 0);
    chk("abort_drained", abort_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_subunit.md
Name: spi_subunit

Overview:
SPI mode-0 peripheral (responder) that pairs with the team's spi_controller, which is the SPI initiator. It oversamples SPI_SCLK, SPI_MOSI and SPI_CS on the system clock through synchronizers and shifts in MOSI MSB-first on SCLK rising edges. It shifts out a user-supplied byte on MISO, with each MISO bit changing after the falling edge on which the controller samples the previous bit. It supports multi-byte frames while CS stays low, and reports received bytes and aborted frames to local logic.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizer on each of SPI_SCLK/SPI_MOSI/SPI_CS (minimum 2)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  reset, asynchronous, active-high
SPI_SCLK  input  1  serial clock from controller; idles low
SPI_MOSI  input  1  serial data from controller
SPI_CS  input  1  chip select, active-low
send_data  input  8  byte to return to controller; sampled at frame start and at each byte boundary
SPI_MISO  output  1  serial data to controller
data_received  output  8  last complete byte received; holds until next byte
received_valid  output  1  one-cycle pulse when data_received updates
busy  output  1  high while a frame is active
abort  output  1  one-cycle pulse when CS rises with a partial byte (1..7 bits) shifted in

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high; it clears all state immediately. Reset values: SPI_MISO=0, data_received=0x00, received_valid=0, busy=0, abort=0, state=IDLE, bit count=0, synchronizer flops=idle values (SCLK 0, MOSI 0, CS 1).
- Synchronizers: each of the three pins passes through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one extra registered copy. Every pin event is therefore seen SYNC_STAGES+1 clk cycles after the pin changes. All three pins share the same depth so MOSI stays aligned with SCLK.
- FSM states: IDLE, ACTIVE.
- IDLE -> ACTIVE on a synchronized CS falling edge.
  - Same cycle: tx shift register <= send_data; SPI_MISO <= send_data[7]; bit count <= 0; busy <= 1.
  - If CS is already low when rst releases, no frame starts until CS goes high and then falls again.
- In ACTIVE, on a synchronized SCLK rising edge:
  - rx shift <= {rx shift[6:0], synced MOSI}; bit count increments.
  - When this is the 8th bit: data_received <= {rx shift[6:0], MOSI}; received_valid pulses next cycle (same edge as the data update); bit count wraps to 0.
- In ACTIVE, on a synchronized SCLK falling edge:
  - If bit count != 0: tx shift left; SPI_MISO <= next bit.
  - If bit count == 0 (byte just completed): tx shift <= send_data; SPI_MISO <= send_data[7]. This reload serves hold_cs multi-byte frames.
  - The first falling edge of a frame therefore presents bit 6. The controller has already sampled bit 7 on that edge.
- MISO update latency: SYNC_STAGES+2 clk after the SCLK pin falls. This is well inside the half-period (100 clk at 100 MHz / 500 kHz).
- ACTIVE -> IDLE on a synchronized CS rising edge:
  - busy <= 0; SPI_MISO <= 0.
  - If bit count != 0, abort pulses for one cycle and the partial byte is discarded (data_received unchanged).
  - If bit count == 0, the frame ended cleanly; no pulse.
- Simultaneous events: a CS rising edge detected in the same cycle as an SCLK edge takes priority, and that SCLK edge is ignored.
- SCLK edges in IDLE are ignored. SPI_MISO is driven 0 whenever not ACTIVE; it is never tristated.
- received_valid and abort are never high in the same cycle.
- send_data must be stable from a byte boundary until the next SCLK falling edge; it is not sampled at any other time.
- Mid-operation reset: all outputs return to reset values immediately. No pulse is emitted for the interrupted frame.

Test Plan:
- Single byte: send_data=0x3C; controller sends 0xA5, hold_cs=0 -> data_received=0xA5 with one received_valid pulse; controller data_received=0x3C; busy high only during CS low; abort never pulses.
- Two-byte frame, hold_cs=1: controller sends 0x81 then 0x7E; send_data changes 0x55→0xAA between bytes -> two received_valid pulses (0x81, 0x7E); controller receives 0x55 then 0xAA.
- Abort: CS forced high after 3 SCLK rising edges with MOSI pattern 1,0,1 -> abort pulses once; data_received keeps its prior value 0xA5; busy=0; SPI_MISO=0.
- Reset mid-frame: assert rst after 4 bits of 0xF0 -> outputs reset immediately. Following frames: CS still low at release -> no frame starts. Next full frame sending 0x0F -> data_received=0x0F.
- Corner data: back-to-back frames of 0x00 and 0xFF with send_data 0xFF/0x00 -> both bytes exact; MISO constant through each byte; no glitches on received_valid.
- Edge latency: check SPI_MISO changes exactly SYNC_STAGES+2 clk after the SCLK pin falls. Check received_valid asserts SYNC_STAGES+2 clk after the 8th SCLK rise.
